// File: rtl/rasterizer_pkg.sv
// Shared types, record layout constants and small bounding-box helpers
// for the triangle setup stage.
package rasterizer_pkg;

    typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} setup_state_t;

    localparam int VX      = 0;
    localparam int VY      = 1;
    localparam int VZ      = 2;
    localparam int VATTR   = 3;
    localparam int COLOR   = 12;
    localparam int FLAGS   = 13;
    localparam int COORD_W = 11;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] clampCoord(input logic [COORD_W-1:0] v,
                                                      input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rasterizer_triangle_setup.sv
// Triangle setup: edge coefficients via one shared multiplier, signed area,
// clipped bounding box, back-face/degenerate culling, valid/stall output.
module rasterizer_triangle_setup
    import rasterizer_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [479:0] vertex_in,
    output logic         stall_out,
    input  logic         done_in,
    output logic         done_out,
    output logic         setup_valid,
    input  logic         stall_in,
    output logic [95:0]  edge_a,
    output logic [95:0]  edge_b,
    output logic [95:0]  edge_c,
    output logic [31:0]  area2,
    output logic [10:0]  bbox_min_x,
    output logic [10:0]  bbox_max_x,
    output logic [10:0]  bbox_min_y,
    output logic [10:0]  bbox_max_y,
    output logic [95:0]  z_out,
    output logic [31:0]  color_out,
    output logic [31:0]  tri_count,
    output logic [31:0]  cull_count
);

    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - 1);

    setup_state_t state_q, state_d;

    logic [2:0]                 step_q;
    logic [2:0][COORD_W-1:0]    x_q, y_q;
    logic [2:0][31:0]           z_q, a_q, b_q, c_q;
    logic [31:0]                color_q, area_q, triCount_q, cullCount_q;
    logic [2*COORD_W-1:0]       prodHold_q;
    logic [COORD_W-1:0]         minX_q, maxX_q, minY_q, maxY_q;
    logic                       done_q;

    logic [COORD_W-1:0]         mulA, mulB;
    logic [2*COORD_W-1:0]       product;
    logic [31:0]                areaSum;
    logic                       areaPositive;
    logic                       unusedRecordBits;

    // Even steps form xa*yb, odd steps xb*ya, for edges 0, 1, 2 in turn.
    always_comb begin
        mulA = '0;
        mulB = '0;
        case (step_q)
            3'd0: begin mulA = x_q[0]; mulB = y_q[1]; end
            3'd1: begin mulA = x_q[1]; mulB = y_q[0]; end
            3'd2: begin mulA = x_q[1]; mulB = y_q[2]; end
            3'd3: begin mulA = x_q[2]; mulB = y_q[1]; end
            3'd4: begin mulA = x_q[2]; mulB = y_q[0]; end
            3'd5: begin mulA = x_q[0]; mulB = y_q[2]; end
            default: ;
        endcase
    end

    assign product          = {{COORD_W{1'b0}}, mulA} * {{COORD_W{1'b0}}, mulB};
    assign areaSum          = c_q[0] + c_q[1] + c_q[2];
    assign areaPositive     = $signed(areaSum) > 0;
    assign unusedRecordBits = ^vertex_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL;
            MUL:     if (step_q == 3'd5) state_d = SUM;
            SUM:     state_d = areaPositive ? OUT : IDLE;
            OUT:     if (!stall_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_out   = (state_q != IDLE);
        setup_valid = (state_q == OUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            color_q     <= '0;
            area_q      <= '0;
            triCount_q  <= '0;
            cullCount_q <= '0;
            prodHold_q  <= '0;
            minX_q      <= '0;
            maxX_q      <= '0;
            minY_q      <= '0;
            maxY_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= done_in && (state_q == IDLE) && !in_valid;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 3; k++) begin
                            x_q[k] <= vertex_in[(4*k+VX)*32+16 +: COORD_W];
                            y_q[k] <= vertex_in[(4*k+VY)*32+16 +: COORD_W];
                            z_q[k] <= vertex_in[(4*k+VZ)*32 +: 32];
                        end
                        color_q    <= vertex_in[COLOR*32 +: 32];
                        triCount_q <= triCount_q + 32'd1;
                        step_q     <= '0;
                    end
                end
                MUL: begin
                    if (step_q == 3'd0) begin
                        for (int k = 0; k < 3; k++) begin
                            a_q[k] <= {21'b0, y_q[k]} - {21'b0, y_q[(k+1)%3]};
                            b_q[k] <= {21'b0, x_q[(k+1)%3]} - {21'b0, x_q[k]};
                        end
                    end
                    if (!step_q[0]) begin
                        prodHold_q <= product;
                    end else begin
                        c_q[step_q[2:1]] <= {10'b0, prodHold_q} - {10'b0, product};
                    end
                    step_q <= step_q + 3'd1;
                end
                SUM: begin
                    area_q <= areaSum;
                    minX_q <= clampCoord(min3(x_q[0], x_q[1], x_q[2]), MAX_X);
                    maxX_q <= clampCoord(max3(x_q[0], x_q[1], x_q[2]), MAX_X);
                    minY_q <= clampCoord(min3(y_q[0], y_q[1], y_q[2]), MAX_Y);
                    maxY_q <= clampCoord(max3(y_q[0], y_q[1], y_q[2]), MAX_Y);
                    if (!areaPositive) begin
                        cullCount_q <= cullCount_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_out   = done_q;
    assign edge_a     = a_q;
    assign edge_b     = b_q;
    assign edge_c     = c_q;
    assign area2      = area_q;
    assign bbox_min_x = minX_q;
    assign bbox_max_x = maxX_q;
    assign bbox_min_y = minY_q;
    assign bbox_max_y = maxY_q;
    assign z_out      = z_q;
    assign color_out  = color_q;
    assign tri_count  = triCount_q;
    assign cull_count = cullCount_q;

endmodule
